vmux_pipe: RTL
==============

# vmux_pipe

Parametrised N-source vector selector for the 3x3-window datapath, successor to the two-input vector mux. Selects one of `NSRC` signed lane vectors per transaction, applies a per-lane mode (select, merge, zero-mask, broadcast), and delivers the result through a registered valid/ready stage with a one-entry skid buffer. It sits between the window/operand registers and the vector ALU so that back-pressure from the ALU never creates a combinational ready path.

## Interface
Parameters:
- `W`, 9: lane width in bits (signed).
- `LANES`, 9: lanes per vector.
- `NSRC`, 4: number of source vectors, minimum 2.
- `SELW`, `$clog2(NSRC)`: select width (derived; do not override).

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset; **synchronous, active-low**.
- `in_valid`  in  1  input transaction present.
- `in_ready`  out  1  block can accept input this cycle.
- `d`  in  `NSRC` x `LANES` x `W` signed  source vectors, `d[s][i]`.
- `sel`  in  `SELW`  source index.
- `mode`  in  2  operation select (see Operation).
- `mask`  in  `LANES`  per-lane enable, bit `i` applies to lane `i`.
- `bidx`  in  `$clog2(LANES)`  broadcast lane index.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts result.
- `y`  out  `LANES` x `W` signed  result vector.
- `err`  out  1  sticky: illegal `sel` or `bidx` was accepted.

## Operation
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`. Inputs (`d`, `sel`, `mode`, `mask`, `bidx`) are sampled only on a transfer in.
- Modes, with `v = d[sel]`:
  - `00` SELECT: `y[i] = v[i]`.
  - `01` MERGE: `y[i] = mask[i] ? v[i] : d[0][i]`.
  - `10` ZMASK: `y[i] = mask[i] ? v[i] : 0`.
  - `11` BCAST: `y[i] = v[bidx]` for all `i`; `mask` is ignored.
- No arithmetic is performed. Values are passed bit-exact and sign is preserved.
- Illegal operands:
  - If `sel >= NSRC`, the result is all-zero.
  - If `mode == 11` and `bidx >= LANES`, the result is all-zero.
  - In either case `err` sets on the transfer in and holds until reset. The transaction still completes normally.
- The state machine covers output-register and skid occupancy:
  - EMPTY (`out_valid=0`).
  - ONE (output register full, skid empty).
  - TWO (both full).
- Transitions:
  - EMPTY + transfer in → ONE.
  - ONE + transfer in + no transfer out → TWO.
  - ONE + transfer out + no transfer in → EMPTY.
  - ONE + both → ONE; the new result replaces the output.
  - TWO + transfer out → ONE; the skid entry moves to the output.
  - TWO never accepts input.
- Ordering is strictly FIFO. No transaction is dropped or duplicated.

## Timing
- Reset: while `rst_n=0` at a rising edge, the next state is:
  - `out_valid=0`, `y` all-zero, `err=0`, skid empty.
  - `in_ready=0` during reset, `1` on the first cycle after `rst_n` is sampled high.
- A reset asserted mid-operation discards both entries with no output beat.
- Latency: a transfer in at edge k gives `out_valid=1` with the result after edge k when the block was EMPTY, or when ONE with a simultaneous transfer out.
- Throughput: one transaction per cycle while `out_ready=1`.
- `in_ready` is a pure register output, equal to NOT TWO. It has no combinational path from `out_ready`.
- `y` and `out_valid` are register outputs. `y` stays stable while `out_valid && !out_ready`.
- `err` is registered and visible the cycle after the offending transfer in.

## Structure
- Package `vmux_pkg`:
  - `vmux_mode_e` enum: `SELECT`, `MERGE`, `ZMASK`, `BCAST`.
  - Default `W`/`LANES` localparams.
  - `lane_t` signed typedef.
  - Occupancy-state enum.
- Sub-module `vmux_skid`: a generic one-entry skid buffer, parametrised on a payload of `LANES*W` bits, with valid/ready on both sides.
- Mode and lane-select logic is a combinational `always_comb` in the top `vmux_pipe`, feeding `vmux_skid`.

## Test plan
- **Reset:** hold `rst_n=0` for 3 cycles with `in_valid=1`. Require `out_valid=0`, `y=0`, `err=0` and `in_ready=0` throughout, then `in_ready=1` on the first cycle after release.
- **SELECT streaming:** NSRC=4, `d[2][i]=i-4`, `sel=2`, `out_ready=1`, 8 back-to-back beats. Require `y[i]=i-4` (covering -4..4, sign intact) one cycle after each beat, with no bubbles.
- **MERGE and ZMASK:**
  - MERGE with `mask=9'b101010101`, `d[1]=all 100`, `d[0]=all -7`. Require `y` to alternate 100/-7, with 100 at lane 0.
  - ZMASK with the same inputs. Require 100/0.
- **BCAST and illegal operands:**
  - BCAST with `bidx=5`, `d[3][5]=-256`. Require all lanes -256.
  - Then `bidx=9`. Require `y=0` and `err=1` on the next cycle, held afterwards.
- **Back-pressure:**
  - Drop `out_ready` with beats A, B, C presented. Require A held, B in the skid, and `in_ready=0` the cycle after B is accepted.
  - Raise `out_ready`. Require the order A, B, C, with no loss or duplication.
- **Simultaneous events and mid-stream reset:**
  - In ONE, assert a transfer in and a transfer out on the same edge. Require the state to stay ONE, `y` to show the new beat, and `in_ready` to stay 1.
  - Assert `rst_n=0` while in TWO. Require both entries to be flushed and `out_valid=0`.

Source files
------------

// File: rtl/vmux_pkg.sv
// vmux_pkg: shared types and default sizes for the vmux_pipe vector selector.
//   vmux_mode_e : per-transaction lane operation
//   vmux_occ_e  : output-register / skid occupancy
//   lane_t      : one signed lane at the default width
package vmux_pkg;

  localparam int unsigned VMUX_W     = 9;
  localparam int unsigned VMUX_LANES = 9;
  localparam int unsigned VMUX_NSRC  = 4;

  typedef logic signed [VMUX_W-1:0] lane_t;

  typedef enum logic [1:0] {
    SELECT = 2'b00,
    MERGE  = 2'b01,
    ZMASK  = 2'b10,
    BCAST  = 2'b11
  } vmux_mode_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_TWO   = 2'b10
  } vmux_occ_e;

endpackage

// File: rtl/vmux_skid.sv
// vmux_skid: one-entry skid buffer behind a registered output stage.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : upstream handshake; in_ready is a flop (NOT TWO)
//   in_data  [DW]       : payload captured on a transfer in
//   out_valid/out_ready : downstream handshake; out_valid is a flop
//   out_data [DW]       : registered payload, stable while stalled
module vmux_skid
  import vmux_pkg::*;
#(
  parameter int unsigned DW = 81
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  vmux_occ_e     state_q, state_d;
  logic [DW-1:0] out_q, out_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;
  logic          xfer_in, xfer_out;

  always_comb begin
    xfer_in  = in_valid && in_ready_q;
    xfer_out = out_valid_q && out_ready;
    state_d  = state_q;
    out_d    = out_q;
    skid_d   = skid_q;
    unique case (state_q)
      OCC_EMPTY: begin
        if (xfer_in) begin
          out_d   = in_data;
          state_d = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (xfer_in && xfer_out) begin
          out_d = in_data;
        end else if (xfer_in) begin
          skid_d  = in_data;
          state_d = OCC_TWO;
        end else if (xfer_out) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        // in_ready_q is low here, so only the drain side can move
        if (xfer_out) begin
          out_d   = skid_q;
          state_d = OCC_ONE;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
    // Handshake flops are computed from the next state so neither output
    // has a combinational path from out_ready.
    out_valid_d = (state_d != OCC_EMPTY);
    in_ready_d  = (state_d != OCC_TWO);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= OCC_EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q;

endmodule

// File: rtl/vmux_pipe.sv
// vmux_pipe: N-source signed vector selector with per-lane mode and a
// registered valid/ready output stage backed by a one-entry skid.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : input handshake (in_ready registered)
//   d[NSRC][LANES][W]   : source vectors
//   sel, mode, mask     : source index, lane operation, per-lane enable
//   bidx                : broadcast lane index
//   out_valid/out_ready : output handshake
//   y[LANES][W]         : registered result
//   err                 : sticky flag, illegal sel/bidx accepted
module vmux_pipe
  import vmux_pkg::*;
#(
  parameter int unsigned W     = VMUX_W,
  parameter int unsigned LANES = VMUX_LANES,
  parameter int unsigned NSRC  = VMUX_NSRC,
  parameter int unsigned SELW  = $clog2(NSRC),
  parameter int unsigned BIDXW = $clog2(LANES)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic signed [NSRC-1:0][LANES-1:0][W-1:0] d,
  input  logic [SELW-1:0]                         sel,
  input  logic [1:0]                              mode,
  input  logic [LANES-1:0]                        mask,
  input  logic [BIDXW-1:0]                        bidx,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic signed [LANES-1:0][W-1:0]          y,
  output logic                                    err
);

  vmux_mode_e                mode_e;
  logic [LANES-1:0][W-1:0]   v;
  logic [LANES-1:0][W-1:0]   res;
  logic [W-1:0]              bv;
  logic                      sel_bad, bidx_bad, illegal;
  logic                      err_q, err_d;

  always_comb begin
    mode_e   = vmux_mode_e'(mode);
    sel_bad  = (32'(sel) >= NSRC);
    bidx_bad = (32'(bidx) >= LANES);
    illegal  = sel_bad || ((mode_e == BCAST) && bidx_bad);

    // Out-of-range indices match no loop iteration and leave zero.
    v = '0;
    for (int unsigned s = 0; s < NSRC; s++) begin
      if (32'(sel) == s) v = d[s];
    end
    bv = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (32'(bidx) == i) bv = v[i];
    end

    res = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      unique case (mode_e)
        SELECT:  res[i] = v[i];
        MERGE:   res[i] = mask[i] ? v[i] : d[0][i];
        ZMASK:   res[i] = mask[i] ? v[i] : '0;
        BCAST:   res[i] = bv;
        default: res[i] = '0;
      endcase
    end
    if (illegal) res = '0;

    err_d = err_q || (in_valid && in_ready && illegal);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;

  vmux_skid #(
    .DW(LANES * W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (res),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (y)
  );

endmodule
